// File: rtl/bram_lsu.sv
// Load/store requester for a single-port 1024x32 synchronous block RAM.
// Handles byte/half/word accesses, with sub-word stores done as read-modify-write.
module bram_lsu #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_data,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wr_data,
  output logic          mem_wen,
  input  logic [31:0]   mem_rd_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    WR_ISSUE,
    RMW_READ,
    RMW_WRITE,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic          resp_err_q, resp_err_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wr_data_q, mem_wr_data_d;
  logic          mem_wen_q, mem_wen_d;

  logic          req_err;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic [31:0]   merged;

  assign req_err = (req_size == 2'd3)
                 | ((req_size == 2'd1) && req_addr[0])
                 | ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
                 | (req_addr[31:AW+2] != '0);

  always_comb begin
    rd_byte  = mem_rd_data[{lane_q, 3'b000} +: 8];
    rd_half  = mem_rd_data[{lane_q[1], 4'b0000} +: 16];
    load_val = mem_rd_data;
    case (size_q)
      2'd0:    load_val = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'd1:    load_val = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = mem_rd_data;
    endcase
    merged = mem_rd_data;
    if (size_q == 2'd0) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    size_d        = size_q;
    uns_d         = uns_q;
    wdata_d       = wdata_q;
    resp_data_d   = resp_data_q;
    resp_err_d    = resp_err_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wen_d     = mem_wen_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lane_d      = req_addr[1:0];
          size_d      = req_size;
          uns_d       = req_unsigned;
          wdata_d     = req_wdata;
          resp_data_d = 32'd0;
          resp_err_d  = 1'b0;
          if (req_err) begin
            resp_err_d = 1'b1;
            state_d    = RESP;
          end else if (!req_we) begin
            mem_addr_d = req_addr[AW+1:2];
            state_d    = RD_ISSUE;
          end else if (req_size == 2'd2) begin
            mem_addr_d    = req_addr[AW+1:2];
            mem_wr_data_d = req_wdata;
            mem_wen_d     = 1'b1;
            state_d       = WR_ISSUE;
          end else begin
            mem_addr_d = req_addr[AW+1:2];
            state_d    = RMW_READ;
          end
        end
      end
      RD_ISSUE: state_d = RD_DATA;
      RD_DATA: begin
        resp_data_d = load_val;
        state_d     = RESP;
      end
      WR_ISSUE: begin
        mem_wen_d = 1'b0;
        state_d   = RESP;
      end
      RMW_READ: begin
        mem_wen_d = 1'b1;
        state_d   = RMW_WRITE;
      end
      RMW_WRITE: begin
        mem_wen_d     = 1'b0;
        mem_wr_data_d = merged;
        state_d       = RESP;
      end
      RESP: begin
        resp_data_d = 32'd0;
        resp_err_d  = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lane_q        <= 2'd0;
      size_q        <= 2'd0;
      uns_q         <= 1'b0;
      wdata_q       <= 32'd0;
      resp_data_q   <= 32'd0;
      resp_err_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= 32'd0;
      mem_wen_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      wdata_q       <= wdata_d;
      resp_data_q   <= resp_data_d;
      resp_err_q    <= resp_err_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wen_q     <= mem_wen_d;
    end
  end

  // Read data only arrives during RMW_WRITE, so the merged word bypasses the register that cycle.
  assign mem_wr_data = (state_q == RMW_WRITE) ? merged : mem_wr_data_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wen     = mem_wen_q;
  assign req_ready   = (state_q == IDLE) && !rst;
  assign resp_valid  = (state_q == RESP);
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_bram_lsu.sv
// Self-checking bench for bram_lsu: a behavioural 1024x32 RAM, a table of
// single requests with hand-computed results, and hand-written reset and back-to-back sequences.
module tb_bram_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wen;
  logic [31:0] mem_rd_data;

  int errors = 0;
  int checks = 0;

  bram_lsu #(.AW(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wen(mem_wen),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_wr_data;
    if (rst) mem_rd_data <= 32'd0;
    else     mem_rd_data <= ram[mem_addr];
  end

  int          wenCount = 0;
  logic [9:0]  lastWenAddr = '0;
  logic [31:0] lastWenData = '0;
  always @(posedge clk) begin
    if (mem_wen) begin
      wenCount    <= wenCount + 1;
      lastWenAddr <= mem_addr;
      lastWenData <= mem_wr_data;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] data;
    logic        err;
    int          wens;
    logic [31:0] wenData;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata,
                               output int lat, output logic [31:0] data, output logic err,
                               output int wens);
    int startW;
    lat  = -1;
    data = 32'hx;
    err  = 1'bx;
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    startW = wenCount;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (resp_valid) begin
        lat  = k;
        data = resp_data;
        err  = resp_err;
        break;
      end
      step();
    end
    step();
    wens = wenCount - startW;
  endtask

  initial begin
    int          lat;
    int          wens;
    logic [31:0] data;
    logic        err;
    int          nAcc;
    int          nResp;
    int          accCyc [4];
    int          respCyc [4];
    logic [31:0] respDat [4];
    logic        accNow;
    int          startW;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = '0; req_unsigned = 1'b0; req_wdata = '0;

    vecs.push_back('{1'b1, 32'h10,   2'd2, 1'b0, 32'hDEADBEEF, 2, 32'h0,        1'b0, 1, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,        3, 32'hDEADBEEF, 1'b0, 0, 32'h0});
    vecs.push_back('{1'b1, 32'h10,   2'd2, 1'b0, 32'h11223344, 2, 32'h0,        1'b0, 1, 32'h11223344});
    vecs.push_back('{1'b1, 32'h13,   2'd0, 1'b0, 32'h000000AB, 3, 32'h0,        1'b0, 1, 32'hAB223344});
    vecs.push_back('{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,        3, 32'hAB223344, 1'b0, 0, 32'h0});
    vecs.push_back('{1'b1, 32'h10,   2'd2, 1'b0, 32'h80FF7F01, 2, 32'h0,        1'b0, 1, 32'h80FF7F01});
    vecs.push_back('{1'b0, 32'h12,   2'd0, 1'b0, 32'h0,        3, 32'hFFFFFFFF, 1'b0, 0, 32'h0});
    vecs.push_back('{1'b0, 32'h12,   2'd0, 1'b1, 32'h0,        3, 32'h000000FF, 1'b0, 0, 32'h0});
    vecs.push_back('{1'b0, 32'h12,   2'd1, 1'b0, 32'h0,        3, 32'hFFFF80FF, 1'b0, 0, 32'h0});
    vecs.push_back('{1'b0, 32'h11,   2'd0, 1'b0, 32'h0,        3, 32'h0000007F, 1'b0, 0, 32'h0});
    vecs.push_back('{1'b1, 32'h10,   2'd1, 1'b0, 32'h1234BEEF, 3, 32'h0,        1'b0, 1, 32'h80FFBEEF});
    vecs.push_back('{1'b0, 32'h10,   2'd1, 1'b1, 32'h0,        3, 32'h0000BEEF, 1'b0, 0, 32'h0});
    vecs.push_back('{1'b0, 32'h10,   2'd1, 1'b0, 32'h0,        3, 32'hFFFFBEEF, 1'b0, 0, 32'h0});
    vecs.push_back('{1'b0, 32'h11,   2'd1, 1'b0, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0});
    vecs.push_back('{1'b1, 32'h12,   2'd2, 1'b0, 32'h55555555, 1, 32'h0,        1'b1, 0, 32'h0});
    vecs.push_back('{1'b0, 32'h10,   2'd3, 1'b0, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0});
    vecs.push_back('{1'b0, 32'h1000, 2'd2, 1'b0, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0});
    vecs.push_back('{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,        3, 32'h80FFBEEF, 1'b0, 0, 32'h0});
    vecs.push_back('{1'b1, 32'h20,   2'd2, 1'b0, 32'h12345678, 2, 32'h0,        1'b0, 1, 32'h12345678});
    vecs.push_back('{1'b1, 32'h30,   2'd2, 1'b0, 32'h0A0A0A0A, 2, 32'h0,        1'b0, 1, 32'h0A0A0A0A});
    vecs.push_back('{1'b1, 32'h34,   2'd2, 1'b0, 32'h0B0B0B0B, 2, 32'h0,        1'b0, 1, 32'h0B0B0B0B});

    step();
    step();
    checkOutput("rst_req_ready",   {31'b0, req_ready},  32'd0);
    checkOutput("rst_resp_valid",  {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_resp_data",   resp_data,           32'd0);
    checkOutput("rst_resp_err",    {31'b0, resp_err},   32'd0);
    checkOutput("rst_mem_addr",    {22'b0, mem_addr},   32'd0);
    checkOutput("rst_mem_wr_data", mem_wr_data,         32'd0);
    checkOutput("rst_mem_wen",     {31'b0, mem_wen},    32'd0);
    rst = 1'b0;
    step();
    checkOutput("idle_req_ready",  {31'b0, req_ready},  32'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                    lat, data, err, wens);
      checkOutput($sformatf("v%0d_latency", i), lat,           vecs[i].lat);
      checkOutput($sformatf("v%0d_data", i),    data,          vecs[i].data);
      checkOutput($sformatf("v%0d_err", i),     {31'b0, err},  {31'b0, vecs[i].err});
      checkOutput($sformatf("v%0d_wens", i),    wens,          vecs[i].wens);
      if (vecs[i].wens == 1) begin
        checkOutput($sformatf("v%0d_wen_addr", i), {22'b0, lastWenAddr}, {22'b0, vecs[i].addr[11:2]});
        checkOutput($sformatf("v%0d_wen_data", i), lastWenData, vecs[i].wenData);
      end
    end

    // Reset while a half store to 0x20 sits in RMW_READ.
    req_we = 1'b1; req_addr = 32'h20; req_size = 2'd1; req_unsigned = 1'b0;
    req_wdata = 32'h0000AAAA; req_valid = 1'b1;
    startW = wenCount;
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    checkOutput("rmwrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rmwrst_mem_wen",    {31'b0, mem_wen},    32'd0);
    checkOutput("rmwrst_req_ready",  {31'b0, req_ready},  32'd0);
    rst = 1'b0;
    step();
    checkOutput("rmwrst_ready_after", {31'b0, req_ready},  32'd1);
    checkOutput("rmwrst_no_resp",     {31'b0, resp_valid}, 32'd0);
    checkOutput("rmwrst_no_write",    wenCount - startW,   32'd0);
    applyStimulus(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, lat, data, err, wens);
    checkOutput("rmwrst_word_kept",   data,                32'h12345678);
    checkOutput("rmwrst_load_lat",    lat,                 32'd3);

    // Two loads with req_valid held high throughout.
    nAcc = 0;
    nResp = 0;
    req_we = 1'b0; req_addr = 32'h30; req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (resp_valid) begin
        if (nResp < 4) begin
          respCyc[nResp] = c;
          respDat[nResp] = resp_data;
        end
        nResp++;
      end
      accNow = req_valid && req_ready;
      if (accNow) begin
        if (nAcc < 4) accCyc[nAcc] = c;
        nAcc++;
      end
      step();
      if (accNow) begin
        if (nAcc == 1) req_addr = 32'h34;
        else           req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checkOutput("b2b_accepts",   nAcc,  32'd2);
    checkOutput("b2b_responses", nResp, 32'd2);
    if (nAcc >= 2 && nResp >= 2) begin
      checkOutput("b2b_second_accept", accCyc[1],  respCyc[0] + 1);
      checkOutput("b2b_first_lat",     respCyc[0], accCyc[0] + 3);
      checkOutput("b2b_data0",         respDat[0], 32'h0A0A0A0A);
      checkOutput("b2b_data1",         respDat[1], 32'h0B0B0B0B);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_lsu.md
# bram_lsu

Load/store requester sitting between the core's memory stage and the single-port, 1024×32 block RAM (synchronous read, registered read data, one-cycle latency, read data forced to 0 while reset is high). Accepts one byte/halfword/word request at a time over a valid/ready handshake and drives the RAM port. Sub-word loads are extracted and extended. Sub-word stores are done as read-modify-write because the RAM has no byte enables. Misaligned and out-of-range requests are rejected with an error response and no RAM access.

## Interface
- AW, 10, RAM word-address width; the addressable space is 4·2^AW bytes.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; 1 only in IDLE with rst low.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_data  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request rejected.
- mem_addr  out  AW  RAM word address, registered.
- mem_wr_data  out  32  RAM write data, registered.
- mem_wen  out  1  RAM write enable, registered.
- mem_rd_data  in  32  RAM read data; valid the cycle after mem_addr is presented with mem_wen=0.

## Operation
- States: IDLE, RD_ISSUE, RD_DATA, WR_ISSUE, RMW_READ, RMW_WRITE, RESP.
- Accept when req_valid && req_ready. All request fields are latched on the accept edge.
- Error check on accept. err = (size==3) | (size==1 && addr[0]) | (size==2 && addr[1:0]!=0) | (addr[31:AW+2]!=0).
  - On error: go to RESP with resp_err=1 and resp_data=0. mem_* are unchanged and mem_wen stays 0.
- Load: IDLE→RD_ISSUE (mem_addr=addr[AW+1:2], wen=0)→RD_DATA (capture and extract mem_rd_data)→RESP.
- Word store: IDLE→WR_ISSUE (mem_wen=1, mem_wr_data=wdata)→RESP.
- Sub-word store: IDLE→RMW_READ (wen=0)→RMW_WRITE (mem_wen=1, same mem_addr, mem_wr_data=merged word)→RESP.
  - The merge writes wdata[7:0] into byte lane addr[1:0], or wdata[15:0] into half lane addr[1].
  - The merge uses mem_rd_data as sampled in RMW_WRITE.
- Load extraction:
  - byte = lane addr[1:0]; half = lane addr[1].
  - Extend to 32 bits per req_unsigned; word loads pass through unchanged.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- mem_wen is 1 only in WR_ISSUE and RMW_WRITE; it is cleared on the edge leaving those states.
- mem_addr and mem_wr_data hold their last values in IDLE.

## Timing
- Accept edge = T. Cycle T+k is the k-th cycle after it.
- resp_valid asserts at:
  - load: T+3;
  - word store: T+2;
  - sub-word store: T+3;
  - error: T+1.
- req_ready is 0 from T+1 until the state returns to IDLE, which is the cycle after RESP. Maximum request rate is one per 4 cycles for loads.
- Word-store write takes effect in the RAM at the end of T+1; sub-word store at the end of T+2. A load accepted afterwards sees the new data.
- Reset values: state IDLE, req_ready=0 while rst=1, resp_valid=0, resp_data=0, resp_err=0, mem_addr=0, mem_wr_data=0, mem_wen=0.
- Reset mid-operation: the state returns to IDLE at the reset edge and no response is issued.
  - A RAM write whose mem_wen was already high in the cycle before reset completes.
  - An RMW caught in RMW_READ performs no write.
- req_valid while req_ready=0 is ignored; the requester must hold it.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load at 0x10.
  - Store: resp_valid at T+2, resp_err=0; mem_wen=1 with mem_addr=4 in exactly one cycle.
  - Load: resp_data=0xDEADBEEF at T+3.
- Byte store 0xAB at 0x13 over 0x11223344, then load word 0x10 → 0xAB223344.
  - Exactly one read cycle then one write cycle to mem_addr=4.
- With the word at 0x10 = 0x80FF7F01:
  - signed byte load at 0x12 → 0xFFFFFFFF;
  - unsigned byte load at 0x12 → 0x000000FF;
  - signed half load at 0x12 → 0xFFFF80FF;
  - signed byte load at 0x11 → 0x0000007F.
- Rejected requests, each giving resp_valid at T+1 with resp_err=1 and no mem_wen pulse:
  - half load at 0x11;
  - word store at 0x12;
  - req_size=3;
  - word load at 0x1000 (AW=10).
- Assert rst in RMW_READ of a half store to 0x20.
  - Next cycle: state IDLE, resp_valid=0, mem_wen=0.
  - Word at 0x20 unchanged; req_ready=1 once rst falls.
- Back-to-back requests with req_valid held high.
  - Second request accepted exactly in the cycle after the first's RESP.
  - No request is lost or duplicated.
